// File: rtl/op_decode_stage_pkg.sv
// Shared decode constants for the op_decode_stage slice.
// Contents: opcode codes, ALU sub-op codes for mult/div, and out_ctrl bit indices.
package op_pkg;

  localparam int unsigned CTRL_W = 16;
  localparam int unsigned OP_W   = 5;

  // Opcodes in instr[31:27]
  localparam logic [OP_W-1:0] OP_ALU  = 5'd0;
  localparam logic [OP_W-1:0] OP_J    = 5'd1;
  localparam logic [OP_W-1:0] OP_BNE  = 5'd2;
  localparam logic [OP_W-1:0] OP_JAL  = 5'd3;
  localparam logic [OP_W-1:0] OP_JR   = 5'd4;
  localparam logic [OP_W-1:0] OP_ADDI = 5'd5;
  localparam logic [OP_W-1:0] OP_BLT  = 5'd6;
  localparam logic [OP_W-1:0] OP_SW   = 5'd7;
  localparam logic [OP_W-1:0] OP_LW   = 5'd8;
  localparam logic [OP_W-1:0] OP_SETX = 5'd21;
  localparam logic [OP_W-1:0] OP_BEX  = 5'd22;

  // ALU sub-ops in instr[6:2] that need the multicycle unit
  localparam logic [OP_W-1:0] ALU_MULT = 5'd6;
  localparam logic [OP_W-1:0] ALU_DIV  = 5'd7;

  // out_ctrl bit positions, LSB first
  localparam int unsigned CB_BNE       = 0;
  localparam int unsigned CB_BLT       = 1;
  localparam int unsigned CB_JAL       = 2;
  localparam int unsigned CB_JUMP      = 3;
  localparam int unsigned CB_J2        = 4;
  localparam int unsigned CB_RD_READ   = 5;
  localparam int unsigned CB_WE_DM     = 6;
  localparam int unsigned CB_WE_REG    = 7;
  localparam int unsigned CB_WE_REG_DM = 8;
  localparam int unsigned CB_ALUOP     = 9;
  localparam int unsigned CB_IMM       = 10;
  localparam int unsigned CB_WE_STATUS = 11;
  localparam int unsigned CB_WE_RETURN = 12;
  localparam int unsigned CB_IS_MD     = 13;
  localparam int unsigned CB_IS_BEX    = 14;
  localparam int unsigned CB_IS_SETX   = 15;

endpackage

// File: rtl/op_decode_comb.sv
// Combinational instruction decoder: instruction word -> control bundle and fields.
// Ports: instr (in); rd_c/rs_c/rt_c, shamt_c, aluop_c, imm_c, target_c, ctrl_c (out, combinational).
module op_decode_comb
  import op_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned IMM_W  = 17,
  parameter int unsigned TGT_W  = 27,
  parameter bit          MD_EN  = 1'b1
) (
  input  logic [DATA_W-1:0] instr,
  output logic [REG_AW-1:0] rd_c,
  output logic [REG_AW-1:0] rs_c,
  output logic [REG_AW-1:0] rt_c,
  output logic [4:0]        shamt_c,
  output logic [4:0]        aluop_c,
  output logic [DATA_W-1:0] imm_c,
  output logic [DATA_W-1:0] target_c,
  output logic [CTRL_W-1:0] ctrl_c
);

  logic [OP_W-1:0] op;
  logic is_alu, is_j, is_bne, is_jal, is_jr, is_addi, is_blt, is_sw, is_lw, is_setx, is_bex;

  assign op       = instr[31:27];
  assign rd_c     = instr[26 -: REG_AW];
  assign rs_c     = instr[21 -: REG_AW];
  assign rt_c     = instr[16 -: REG_AW];
  assign shamt_c  = instr[11:7];
  assign aluop_c  = instr[6:2];
  assign imm_c    = {{(DATA_W-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
  assign target_c = {{(DATA_W-TGT_W){1'b0}}, instr[TGT_W-1:0]};

  assign is_alu  = (op == OP_ALU);
  assign is_j    = (op == OP_J);
  assign is_bne  = (op == OP_BNE);
  assign is_jal  = (op == OP_JAL);
  assign is_jr   = (op == OP_JR);
  assign is_addi = (op == OP_ADDI);
  assign is_blt  = (op == OP_BLT);
  assign is_sw   = (op == OP_SW);
  assign is_lw   = (op == OP_LW);
  assign is_setx = (op == OP_SETX);
  assign is_bex  = (op == OP_BEX);

  // Control equations; unknown opcodes leave every bit clear (nop)
  always_comb begin
    ctrl_c               = '0;
    ctrl_c[CB_BNE]       = is_bne;
    ctrl_c[CB_BLT]       = is_blt;
    ctrl_c[CB_JAL]       = is_jal;
    ctrl_c[CB_JUMP]      = is_j | is_jal | is_jr | is_bex;
    ctrl_c[CB_J2]        = is_jr;
    ctrl_c[CB_RD_READ]   = is_sw | is_bne | is_blt | is_jr;
    ctrl_c[CB_WE_DM]     = is_sw;
    ctrl_c[CB_WE_REG]    = is_alu | is_jal | is_addi | is_lw | is_setx;
    ctrl_c[CB_WE_REG_DM] = is_lw;
    ctrl_c[CB_ALUOP]     = is_alu;
    ctrl_c[CB_IMM]       = is_bne | is_blt | is_sw | is_lw | is_addi;
    ctrl_c[CB_WE_STATUS] = is_alu | is_addi;
    ctrl_c[CB_WE_RETURN] = is_jal;
    ctrl_c[CB_IS_MD]     = MD_EN & is_alu & ((aluop_c == ALU_MULT) | (aluop_c == ALU_DIV));
    ctrl_c[CB_IS_BEX]    = is_bex;
    ctrl_c[CB_IS_SETX]   = is_setx;
  end

endmodule

// File: rtl/op_decode_stage.sv
// Registered decode stage with valid/ready on both sides, load-use bubble and mult/div interlock.
// Ports: clock, reset (async high), flush; in_valid/in_ready/in_instr/in_pc from fetch;
//        out_valid/out_ready and registered out_* bundle to execute; md_done in, md_busy out.
module op_decode_stage
  import op_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned IMM_W  = 17,
  parameter int unsigned TGT_W  = 27,
  parameter bit          MD_EN  = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [REG_AW-1:0] out_rd,
  output logic [REG_AW-1:0] out_rs,
  output logic [REG_AW-1:0] out_rt,
  output logic [4:0]        out_shamt,
  output logic [4:0]        out_aluop,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_target,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              md_done,
  output logic              md_busy
);

  logic [REG_AW-1:0] dec_rd, dec_rs, dec_rt;
  logic [4:0]        dec_shamt, dec_aluop;
  logic [DATA_W-1:0] dec_imm, dec_target;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              load, rd_hit, lu_hazard, md_stall, accept, issue;

  op_decode_comb #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .IMM_W(IMM_W), .TGT_W(TGT_W), .MD_EN(MD_EN)
  ) u_dec (
    .instr    (in_instr),
    .rd_c     (dec_rd),
    .rs_c     (dec_rs),
    .rt_c     (dec_rt),
    .shamt_c  (dec_shamt),
    .aluop_c  (dec_aluop),
    .imm_c    (dec_imm),
    .target_c (dec_target),
    .ctrl_c   (dec_ctrl)
  );

  // Incoming instruction reads the register the resident lw is writing
  assign rd_hit = (dec_rs == out_rd)
                | (dec_ctrl[CB_ALUOP]   & (dec_rt == out_rd))
                | (dec_ctrl[CB_RD_READ] & (dec_rd == out_rd));
  assign lu_hazard = out_valid & out_ctrl[CB_WE_REG_DM] & (out_rd != '0) & rd_hit;

  // md_done releases issue in the same cycle it arrives
  assign md_stall = md_busy & ~md_done;

  assign load     = ~out_valid | out_ready;
  assign in_ready = ~reset & load & ~lu_hazard & ~md_stall;
  assign accept   = in_valid & in_ready;
  assign issue    = out_valid & out_ready;

  // Output bundle register; a stalled load cycle leaves out_valid low, forming the bubble
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_rd     <= '0;
      out_rs     <= '0;
      out_rt     <= '0;
      out_shamt  <= '0;
      out_aluop  <= '0;
      out_imm    <= '0;
      out_target <= '0;
      out_ctrl   <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (load) begin
        out_valid <= accept;
      end
      if (!flush && accept) begin
        out_pc     <= in_pc;
        out_rd     <= dec_rd;
        out_rs     <= dec_rs;
        out_rt     <= dec_rt;
        out_shamt  <= dec_shamt;
        out_aluop  <= dec_aluop;
        out_imm    <= dec_imm;
        out_target <= dec_target;
        out_ctrl   <= dec_ctrl;
      end
    end
  end

  // Outstanding mult/div tracker; a new issue outranks a coincident md_done
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      md_busy <= 1'b0;
    end else if (issue && out_ctrl[CB_IS_MD]) begin
      md_busy <= 1'b1;
    end else if (md_done) begin
      md_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_op_decode_stage.sv
// Directed self-checking bench for op_decode_stage.
module tb_op_decode_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [4:0]  out_rd, out_rs, out_rt, out_shamt, out_aluop;
  logic [31:0] out_imm, out_target;
  logic [15:0] out_ctrl;
  logic        md_done = 1'b0;
  logic        md_busy;

  int checks = 0;
  int failures = 0;

  op_decode_stage dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
    .out_shamt(out_shamt), .out_aluop(out_aluop),
    .out_imm(out_imm), .out_target(out_target), .out_ctrl(out_ctrl),
    .md_done(md_done), .md_busy(md_busy)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    // Reset state
    #2 reset = 1'b1;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_md_busy",   32'(md_busy),   32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_pc",    out_pc,         32'd0);
    chk("rst_out_ctrl",  32'(out_ctrl),  32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1 chk("ready_after_reset", 32'(in_ready), 32'd1);

    // addi r2,r5,5
    out_ready = 1'b1;
    present(32'h288A_0005, 32'h100);
    @(negedge clock);
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_rd",    32'(out_rd),    32'd2);
    chk("addi_rs",    32'(out_rs),    32'd5);
    chk("addi_imm",   out_imm,        32'd5);
    chk("addi_ctrl",  32'(out_ctrl),  32'h0C80);
    chk("addi_pc",    out_pc,         32'h100);

    // addi r1, imm field all ones
    present(32'h2841_FFFF, 32'h104);
    @(negedge clock);
    chk("negimm_imm", out_imm,        32'hFFFF_FFFF);
    chk("negimm_rt",  32'(out_rt),    32'h1F);
    chk("negimm_rd",  32'(out_rd),    32'd1);
    chk("negimm_pc",  out_pc,         32'h104);

    // Back-pressure: add r4,r5,r6 waits while the bundle is held
    out_ready = 1'b0;
    present(32'h010A_6000, 32'h108);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clock);
      chk("bp_hold_pc",  out_pc,  32'h104);
      chk("bp_hold_imm", out_imm, 32'hFFFF_FFFF);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_next_pc",    out_pc,         32'h108);
    chk("bp_next_rt",    32'(out_rt),    32'd6);
    chk("bp_next_ctrl",  32'(out_ctrl),  32'h0A80);
    in_valid = 1'b0;
    @(negedge clock);
    chk("bp_no_dup", 32'(out_valid), 32'd0);

    // Load-use: lw r3,0(r1) then add r4,r3,r2
    present(32'h40C2_0000, 32'h200);
    @(negedge clock);
    chk("lw_ctrl", 32'(out_ctrl), 32'h0580);
    present(32'h0106_2000, 32'h204);
    #1 chk("lu_stall", 32'(in_ready), 32'd0);
    @(negedge clock);
    chk("lu_bubble", 32'(out_valid), 32'd0);
    #1 chk("lu_ready_after", 32'(in_ready), 32'd1);
    @(negedge clock);
    chk("lu_add_valid", 32'(out_valid), 32'd1);
    chk("lu_add_pc",    out_pc,         32'h204);
    in_valid = 1'b0;
    @(negedge clock);

    // Same pattern through r0: no bubble
    present(32'h4002_0000, 32'h300);
    @(negedge clock);
    present(32'h0100_2000, 32'h304);
    #1 chk("lu_r0_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    chk("lu_r0_valid", 32'(out_valid), 32'd1);
    chk("lu_r0_pc",    out_pc,         32'h304);
    in_valid = 1'b0;
    @(negedge clock);

    // Stray md_done while idle
    md_done = 1'b1;
    @(negedge clock);
    md_done = 1'b0;
    chk("stray_md_done", 32'(md_busy), 32'd0);

    // mult r1,r2,r3 then interlock
    present(32'h0044_3018, 32'h400);
    @(negedge clock);
    chk("mult_ctrl",     32'(out_ctrl), 32'h2A80);
    chk("mult_busy_pre", 32'(md_busy),  32'd0);
    in_valid = 1'b0;
    @(negedge clock);
    chk("mult_busy", 32'(md_busy), 32'd1);
    present(32'h288A_0005, 32'h500);
    for (int i = 0; i < 20; i++) begin
      #1 chk("md_stall_ready", 32'(in_ready), 32'd0);
      @(negedge clock);
    end
    chk("md_still_busy", 32'(md_busy), 32'd1);
    md_done = 1'b1;
    #1 chk("md_done_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    md_done = 1'b0;
    chk("md_cleared",   32'(md_busy),   32'd0);
    chk("md_next_valid", 32'(out_valid), 32'd1);
    chk("md_next_pc",   out_pc,         32'h500);
    in_valid = 1'b0;
    @(negedge clock);

    // Flush while a bundle is held and another is offered
    present(32'h010A_6000, 32'h600);
    @(negedge clock);
    chk("fl_held_pc", out_pc, 32'h600);
    out_ready = 1'b0;
    present(32'h010A_6000, 32'h604);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    chk("fl_held_kill", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clock);
    chk("fl_held_gone", 32'(out_valid), 32'd0);

    // Flush while an instruction would be accepted
    present(32'h010A_6000, 32'h680);
    flush = 1'b1;
    @(negedge clock);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_drop", 32'(out_valid), 32'd0);
    @(negedge clock);
    chk("fl_drop_gone", 32'(out_valid), 32'd0);

    // Async reset with a mult outstanding
    present(32'h0044_3018, 32'h700);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    chk("rm_busy", 32'(md_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("rm_md_busy",   32'(md_busy),   32'd0);
    chk("rm_out_valid", 32'(out_valid), 32'd0);
    chk("rm_in_ready",  32'(in_ready),  32'd0);
    chk("rm_out_pc",    out_pc,         32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rm_after_valid", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
